// File: rtl/pipe_add_arbiter_pkg.sv
// Shared definitions for the pipelined-adder arbiter slice.
//   id_width() : requester index width for a given requester count
//   tag_t      : {valid, id} record carried alongside the PE pipeline
//   UiAddLat   : default latency of the ui_add processing element
package pipe_add_arbiter_pkg;

    localparam int unsigned MaxReq   = 16;
    localparam int unsigned MaxIdW   = 4;
    localparam int unsigned UiAddLat = 1;

    typedef struct packed {
        logic              valid;
        logic [MaxIdW-1:0] id;
    } tag_t;

    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/pipe_add_arbiter_rr_arbiter.sv
// Round-robin arbiter with one-hot grant and update-on-accept pointer.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   en_i     : grant enable; 0 forces an empty grant
//   req_i    : per-requester request vector
//   gnt_o    : one-hot grant (only ever set on a requesting lane)
//   gnt_id_o : index of the granted lane
//   gnt_any_o: a grant (and therefore a handshake) is happening this cycle
module pipe_add_arbiter_rr_arbiter
    import pipe_add_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdW  = id_width(NREQ)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdW-1:0]  gnt_id_o,
    output logic            gnt_any_o
);

    logic [IdW-1:0] ptr_q, ptr_d;
    int unsigned    idx;

    // Search starts one past the last winner so the winner drops to lowest priority.
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (en_i && !gnt_any_o && req_i[idx]) begin
                gnt_any_o     = 1'b1;
                gnt_o[idx]    = 1'b1;
                gnt_id_o      = IdW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any_o) begin
            ptr_d = gnt_id_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= IdW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pipe_add_arbiter.sv
// Shares one pipelined adder PE between NREQ requesters. A round-robin arbiter
// issues at most one op per cycle; a {valid, id} tag pipe tracks each op through
// the PE so the result returns on a registered, one-hot response port.
//   clk, rst            : clock, asynchronous active-high reset
//   en, pe_cts          : issue enable / PE clear-to-send (both gate grants)
//   req_valid/req_ready : per-lane request and one-hot grant
//   req_in1/req_in2     : flattened operands, lane i at [i*N +: N]
//   pe_in1/pe_in2/pe_out: PE operand outputs and result input
//   rsp_valid/id/data   : one-hot result strobe, owner index, sum mod 2^N
//   inflight            : ops issued but not yet responded
//   issued_cnt          : handshakes since reset (wrapping)
module pipe_add_arbiter
    import pipe_add_arbiter_pkg::*;
#(
    parameter int unsigned N    = 64,
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = UiAddLat,
    parameter int unsigned CNTW = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*N-1:0]           req_in1,
    input  logic [NREQ*N-1:0]           req_in2,
    input  logic                        pe_cts,
    output logic [N-1:0]                pe_in1,
    output logic [N-1:0]                pe_in2,
    input  logic [N-1:0]                pe_out,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [$clog2(NREQ)-1:0]     rsp_id,
    output logic [N-1:0]                rsp_data,
    output logic [$clog2(LAT+2)-1:0]    inflight,
    output logic [CNTW-1:0]             issued_cnt
);

    localparam int unsigned IdW  = id_width(NREQ);
    localparam int unsigned InfW = $clog2(LAT + 2);

    logic            arb_en;
    logic            hs;
    logic [NREQ-1:0] gnt;
    logic [IdW-1:0]  gnt_id;

    // Gating with rst keeps req_ready low for the whole reset pulse.
    assign arb_en = en & pe_cts & ~rst;

    pipe_add_arbiter_rr_arbiter #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_rr_arbiter (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (arb_en),
        .req_i     (req_valid),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_any_o (hs)
    );

    assign req_ready = gnt;

    always_comb begin
        pe_in1 = '0;
        pe_in2 = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                pe_in1 = req_in1[i*N +: N];
                pe_in2 = req_in2[i*N +: N];
            end
        end
    end

    // Tag pipe: stage LAT-1 lines up with the PE result for the same op.
    tag_t tag_q [LAT];
    tag_t tag_in;
    tag_t tag_out;
    logic rsp_fire;
    logic unused_tag_id;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = hs;
        tag_in.id    = MaxIdW'(gnt_id);
    end

    assign tag_out       = tag_q[LAT-1];
    assign rsp_fire      = tag_out.valid;
    assign unused_tag_id = ^tag_out.id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int unsigned s = 1; s < LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // Response register; id/data hold when no result is returning.
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [IdW-1:0]  rsp_id_q, rsp_id_d;
    logic [N-1:0]    rsp_data_q, rsp_data_d;

    always_comb begin
        rsp_valid_d = '0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_fire) begin
            rsp_valid_d = NREQ'(1) << tag_out.id[IdW-1:0];
            rsp_id_d    = tag_out.id[IdW-1:0];
            rsp_data_d  = pe_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    // Counters.
    logic [InfW-1:0] inflight_q, inflight_d;
    logic [CNTW-1:0] issued_cnt_q, issued_cnt_d;

    always_comb begin
        inflight_d = inflight_q;
        if (hs && !rsp_fire) begin
            inflight_d = inflight_q + InfW'(1);
        end else if (!hs && rsp_fire) begin
            inflight_d = inflight_q - InfW'(1);
        end
        issued_cnt_d = hs ? issued_cnt_q + CNTW'(1) : issued_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q   <= '0;
            issued_cnt_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign inflight   = inflight_q;
    assign issued_cnt = issued_cnt_q;

endmodule
